weight_arbiter: RTL and testbench
=================================

WEIGHT_ARBITER -- requirements
Module: weight_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of synapse requesters sharing one weight BRAM read port.
REQ-002 Parameter ADDR_W, default 17: weight BRAM address width.
REQ-003 Parameter DATA_W, default 32: weight word width.
REQ-004 Parameter READ_LAT, default 1: BRAM read latency in clocks, legal range 1..4.
REQ-005 Clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Rst  input  1: reset, asynchronous and active-high.
REQ-007 Enable  input  1: high permits new grants; low stops new grants and lets in-flight reads finish.
REQ-008 ReqValid  input  NUM_REQ: per-requester read request.
REQ-009 ReqAddr  input  NUM_REQ*ADDR_W: per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 ReqReady  output  NUM_REQ: one-hot grant; a transfer occurs when ReqValid[i] and ReqReady[i] are both high at a clock edge.
REQ-011 BramEn  output  1: BRAM read enable.
REQ-012 BramAddr  output  ADDR_W: BRAM read address.
REQ-013 BramDout  input  DATA_W: BRAM read data, valid READ_LAT clocks after BramEn.
REQ-014 RspValid  output  NUM_REQ: one-hot response strobe, one clock wide.
REQ-015 RspData  output  DATA_W: weight word returned with RspValid.
REQ-016 Busy  output  1: high while any read is in flight or the FSM is not IDLE.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 IDLE -> RUN when Enable=1.
REQ-019 RUN -> DRAIN when Enable=0.
REQ-020 DRAIN -> IDLE when no reads are in flight.
REQ-021 DRAIN -> RUN when Enable=1 returns before the drain completes.
REQ-022 Grants are issued only in RUN.
REQ-023 In RUN, at most one ReqReady bit is high per cycle. The selected requester is the lowest index i such that ReqValid[i]=1, scanning circularly from pointer Ptr.
REQ-024 ReqReady is combinational from ReqValid, Ptr and state. It is all-zero when no request is pending.
REQ-025 On a transfer, BramEn=1 and BramAddr=ReqAddr of the granted requester in the same cycle. Both are combinational from the grant.
REQ-026 When no grant is issued, BramEn=0 and BramAddr=0.
REQ-027 On a transfer to requester g, Ptr updates at the clock edge to g+1, wrapping to 0 after NUM_REQ-1. Ptr holds when there is no transfer.
REQ-028 Ptr is ceil(log2 NUM_REQ) bits wide, with minimum width 1.
REQ-029 The grant tag (one-hot NUM_REQ) is carried through a READ_LAT-stage shift register.
REQ-030 RspValid equals the tag emerging READ_LAT clocks after the transfer. RspData equals BramDout in that same cycle.
REQ-031 RspData is 0 when RspValid=0.
REQ-032 Throughput is one grant per clock sustained. The pipeline never stalls: requesters must accept RspValid unconditionally.
REQ-033 A requester that drops ReqValid before being granted loses its slot with no side effect. ReqAddr is sampled only at the transfer edge.
REQ-034 When all requesters are continuously valid, each is granted exactly once every NUM_REQ cycles.
REQ-035 When Enable falls in the same cycle as a pending request, no grant is issued that cycle.
REQ-036 Responses already in flight during DRAIN are still delivered.
REQ-037 Busy = (state != IDLE) OR (any tag stage non-zero).

Reset
REQ-038 While Rst=1: state=IDLE, Ptr=0, all tag stages=0, ReqReady=0, BramEn=0, BramAddr=0, RspValid=0, RspData=0, Busy=0.
REQ-039 Rst asserted mid-operation discards in-flight tags immediately. No RspValid is produced for reads issued before reset.
REQ-040 After Rst deasserts, the first grant can occur in the first clock in which the state is RUN.

Verification
REQ-041 Single request: Enable=1, ReqValid=0001, ReqAddr0=0x00010 -> ReqReady=0001, BramEn=1, BramAddr=0x00010 in that cycle; RspValid=0001 with RspData=BramDout exactly 1 clock later (READ_LAT=1).
REQ-042 Round robin: Enable=1, ReqValid=1111 held for 8 clocks after reset -> grant sequence 0,1,2,3,0,1,2,3, with RspValid following each grant 1 clock later.
REQ-043 Pointer skip: Ptr=2, ReqValid=0011 -> requester 0 is granted; Ptr becomes 1 next cycle; the next grant goes to requester 1.
REQ-044 Drain: with READ_LAT=3, a grant at cycle t and Enable=0 at t+1 -> no further grants; RspValid at t+3; Busy=1 through t+3 and 0 at t+4; state returns to IDLE.
REQ-045 Reset mid-flight: with READ_LAT=2, a grant at cycle t and Rst=1 at t+1 -> RspValid stays 0 at t+2; all outputs are 0 while Rst=1.
REQ-046 Disabled: Enable=0, ReqValid=1111 for 10 clocks -> ReqReady=0, BramEn=0, Busy=0 throughout.

Source files
------------

// File: rtl/weight_arbiter.sv
// Round-robin arbiter sharing one weight BRAM read port among NUM_REQ synapse requesters.
// Grant tags travel a READ_LAT-deep shift register so each word returns to the requester that asked.
module weight_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      bram_en_o,
   output logic [ADDR_W-1:0]         bram_addr_o,
   input  logic [DATA_W-1:0]         bram_dout_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_data_o,
   output logic                      busy_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // state | meaning
   // IDLE  | no grants, nothing in flight
   // RUN   | grants issued while enable_i is high
   // DRAIN | no grants, waiting for in-flight reads to return
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   ptr_d;
   logic [NUM_REQ-1:0] tag_q [READ_LAT];

   logic               run_ok;
   logic               gnt_vld;
   logic [PTR_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] gnt_oh;
   logic [ADDR_W-1:0]  gnt_addr;
   logic               tags_busy;
   logic               inflight_next;

   assign run_ok = (state_q == RUN) && enable_i;

   always_comb begin
      logic [PTR_W-1:0] idx;
      idx     = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!gnt_vld && run_ok && req_valid_i[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   always_comb begin
      gnt_oh   = '0;
      gnt_addr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_vld && gnt_idx == PTR_W'(k)) begin
            gnt_oh[k] = 1'b1;
            gnt_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld) begin
         ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

   // The last stage is delivering this cycle, so only earlier stages keep DRAIN alive.
   always_comb begin
      tags_busy     = 1'b0;
      inflight_next = 1'b0;
      for (int s = 0; s < READ_LAT; s++) begin
         tags_busy = tags_busy | (|tag_q[s]);
         if (s < READ_LAT-1) begin
            inflight_next = inflight_next | (|tag_q[s]);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         for (int s = 0; s < READ_LAT; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         case (state_q)
            IDLE:    if (enable_i) state_q <= RUN;
            RUN:     if (!enable_i) state_q <= DRAIN;
            DRAIN: begin
               if (enable_i) begin
                  state_q <= RUN;
               end else if (!inflight_next) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         ptr_q    <= ptr_d;
         tag_q[0] <= gnt_oh;
         for (int s = 1; s < READ_LAT; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   assign req_ready_o = gnt_oh;
   assign bram_en_o   = gnt_vld;
   assign bram_addr_o = gnt_addr;
   assign rsp_valid_o = tag_q[READ_LAT-1];
   assign rsp_data_o  = (|tag_q[READ_LAT-1]) ? bram_dout_i : '0;
   assign busy_o      = (state_q != IDLE) || tags_busy;

endmodule

// File: tb/tb_weight_arbiter.sv
// Bench for weight_arbiter: three instances (READ_LAT 1..3) share stimulus and are checked
// against a cycle-level reference model of the arbitration rules plus directed scenarios.
module tb_weight_arbiter;

   localparam int N  = 4;
   localparam int AW = 17;
   localparam int DW = 32;
   localparam int NI = 3;
   localparam int PW = 2*N + AW + DW + 2;
   localparam logic [N-1:0] ONE = 1;

   typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_t;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            enable_i;
   logic [N-1:0]    req_valid_i;
   logic [N*AW-1:0] req_addr_i;
   logic [DW-1:0]   bram_dout_i;

   logic [N-1:0]  rr   [NI];
   logic          en   [NI];
   logic [AW-1:0] ba   [NI];
   logic [N-1:0]  rv   [NI];
   logic [DW-1:0] rd   [NI];
   logic          busy [NI];

   always #5 clk_i = ~clk_i;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      weight_arbiter #(
         .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(k+1)
      ) u_dut (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .enable_i    (enable_i),
         .req_valid_i (req_valid_i),
         .req_addr_i  (req_addr_i),
         .req_ready_o (rr[k]),
         .bram_en_o   (en[k]),
         .bram_addr_o (ba[k]),
         .bram_dout_i (bram_dout_i),
         .rsp_valid_o (rv[k]),
         .rsp_data_o  (rd[k]),
         .busy_o      (busy[k])
      );
   end

   // reference model: hist[j] is the grant issued j+1 cycles ago
   mstate_t      m_state [NI];
   int           m_ptr;
   int           m_g;
   logic [N-1:0] m_gnt;
   logic [N-1:0] m_hist [NI];

   logic [PW-1:0] act_pk [NI];
   logic [PW-1:0] exp_pk [NI];
   logic [N-1:0]  a_rr   [NI];
   logic          a_en   [NI];
   logic [AW-1:0] a_ba   [NI];
   logic [N-1:0]  a_rv   [NI];
   logic [DW-1:0] a_rd   [NI];
   logic          a_busy [NI];
   logic [DW-1:0] d_smp;

   int n_vec = 0;
   int n_err = 0;

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_state[k] = M_IDLE;
         m_hist[k]  = '0;
      end
      m_ptr = 0;
      m_g   = -1;
      m_gnt = '0;
   endtask

   task automatic model_eval();
      logic [N-1:0]  e_rr;
      logic [AW-1:0] e_ba;
      logic [DW-1:0] e_rd;
      logic          e_busy;
      if (rst_i) model_reset();
      m_g = -1;
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (m_ptr + i) % N;
         if (m_g < 0 && ((req_valid_i >> idx) & ONE) != '0) m_g = idx;
      end
      m_gnt = (m_state[0] == M_RUN && enable_i && m_g >= 0) ? (ONE << m_g) : '0;
      for (int k = 0; k < NI; k++) begin
         e_rr = (m_state[k] == M_RUN && enable_i && m_g >= 0) ? (ONE << m_g) : '0;
         e_ba = (e_rr != '0) ? AW'(req_addr_i >> (m_g*AW)) : '0;
         e_rd = (m_hist[k] != '0) ? bram_dout_i : '0;
         e_busy = (m_state[k] != M_IDLE);
         for (int j = 0; j <= k; j++) e_busy = e_busy | (m_hist[j] != '0);
         exp_pk[k] = {e_rr, (e_rr != '0), e_ba, m_hist[k], e_rd, e_busy};
      end
   endtask

   task automatic model_update();
      logic pending;
      if (rst_i) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NI; k++) begin
         pending = 1'b0;
         for (int j = 0; j < k; j++) pending = pending | (m_hist[j] != '0);
         case (m_state[k])
            M_IDLE:  if (enable_i) m_state[k] = M_RUN;
            M_RUN:   if (!enable_i) m_state[k] = M_DRAIN;
            default: if (enable_i) m_state[k] = M_RUN;
                     else if (!pending) m_state[k] = M_IDLE;
         endcase
      end
      for (int j = NI-1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_gnt;
      if (m_gnt != '0) m_ptr = (m_g + 1) % N;
   endtask

   task automatic run_cycle();
      bram_dout_i = $urandom();
      @(negedge clk_i);
      model_eval();
      for (int k = 0; k < NI; k++) begin
         a_rr[k] = rr[k]; a_en[k] = en[k]; a_ba[k] = ba[k];
         a_rv[k] = rv[k]; a_rd[k] = rd[k]; a_busy[k] = busy[k];
         act_pk[k] = {rr[k], en[k], ba[k], rv[k], rd[k], busy[k]};
      end
      d_smp = bram_dout_i;
      @(posedge clk_i);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; enable_i = 1'b0; req_valid_i = '0;
      run_cycle();
      rst_i = 1'b0;
   endtask

   task automatic rand_addr();
      req_addr_i = (N*AW)'({$urandom(), $urandom(), $urandom()});
   endtask

   task automatic test_reset();
      rst_i = 1'b1; enable_i = 1'b1; req_valid_i = 4'hF; rand_addr();
      repeat (3) begin
         run_cycle();
         for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (act_pk[k] !== '0) begin
               n_err++;
               $display("FAIL reset_outputs L=%0d: got %h want 0", k+1, act_pk[k]);
            end
         end
      end
      rst_i = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      enable_i = 1'b1; req_valid_i = '0; rand_addr();
      run_cycle();
      req_valid_i = 4'b0001; req_addr_i[AW-1:0] = 17'h00010;
      run_cycle();
      n_vec++;
      if (a_rr[0] !== 4'b0001 || a_en[0] !== 1'b1 || a_ba[0] !== 17'h00010) begin
         n_err++;
         $display("FAIL single_grant: got rdy=%b en=%b addr=%h want 0001/1/00010", a_rr[0], a_en[0], a_ba[0]);
      end
      req_valid_i = '0;
      run_cycle();
      n_vec++;
      if (a_rv[0] !== 4'b0001 || a_rd[0] !== d_smp) begin
         n_err++;
         $display("FAIL single_rsp: got rv=%b data=%h want 0001/%h", a_rv[0], a_rd[0], d_smp);
      end
      for (int k = 0; k < NI; k++) begin
         n_vec++;
         if (act_pk[k] !== exp_pk[k]) begin
            n_err++;
            $display("FAIL single_model L=%0d: got %h want %h", k+1, act_pk[k], exp_pk[k]);
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      enable_i = 1'b1; req_valid_i = '0;
      run_cycle();
      req_valid_i = 4'hF;
      for (int i = 0; i < 8; i++) begin
         rand_addr();
         run_cycle();
         n_vec++;
         if (a_rr[0] !== (ONE << (i % 4))) begin
            n_err++;
            $display("FAIL rr_grant[%0d]: got %b want %b", i, a_rr[0], ONE << (i % 4));
         end
         if (i > 0) begin
            n_vec++;
            if (a_rv[0] !== (ONE << ((i-1) % 4))) begin
               n_err++;
               $display("FAIL rr_rsp[%0d]: got %b want %b", i, a_rv[0], ONE << ((i-1) % 4));
            end
         end
         for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (act_pk[k] !== exp_pk[k]) begin
               n_err++;
               $display("FAIL rr_model L=%0d: got %h want %h", k+1, act_pk[k], exp_pk[k]);
            end
         end
      end
   endtask

   task automatic test_ptr_skip();
      do_reset();
      enable_i = 1'b1; req_valid_i = '0; rand_addr();
      run_cycle();
      req_valid_i = 4'b0010;
      run_cycle();
      req_valid_i = 4'b0011;
      run_cycle();
      n_vec++;
      if (a_rr[0] !== 4'b0001) begin
         n_err++;
         $display("FAIL skip_first: got %b want 0001", a_rr[0]);
      end
      run_cycle();
      n_vec++;
      if (a_rr[0] !== 4'b0010) begin
         n_err++;
         $display("FAIL skip_second: got %b want 0010", a_rr[0]);
      end
   endtask

   task automatic test_drain();
      logic [N-1:0] rv_tab [4];
      logic         bz_tab [4];
      rv_tab = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
      bz_tab = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      enable_i = 1'b1; req_valid_i = '0; rand_addr();
      run_cycle();
      req_valid_i = 4'b0100;
      run_cycle();
      enable_i = 1'b0; req_valid_i = 4'hF;
      for (int c = 0; c < 4; c++) begin
         run_cycle();
         n_vec++;
         if (a_rr[2] !== 4'b0 || a_rv[2] !== rv_tab[c] || a_busy[2] !== bz_tab[c]) begin
            n_err++;
            $display("FAIL drain t+%0d: got rdy=%b rv=%b busy=%b want 0000/%b/%b",
                     c+1, a_rr[2], a_rv[2], a_busy[2], rv_tab[c], bz_tab[c]);
         end
         for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (act_pk[k] !== exp_pk[k]) begin
               n_err++;
               $display("FAIL drain_model L=%0d: got %h want %h", k+1, act_pk[k], exp_pk[k]);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      enable_i = 1'b1; req_valid_i = '0; rand_addr();
      run_cycle();
      req_valid_i = 4'b1000;
      run_cycle();
      rst_i = 1'b1;
      repeat (2) begin
         run_cycle();
         for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (act_pk[k] !== '0) begin
               n_err++;
               $display("FAIL midflight_reset L=%0d: got %h want 0", k+1, act_pk[k]);
            end
         end
      end
      rst_i = 1'b0; req_valid_i = '0;
      run_cycle();
      n_vec++;
      if (a_rv[1] !== 4'b0) begin
         n_err++;
         $display("FAIL midflight_after: got rv=%b want 0000", a_rv[1]);
      end
   endtask

   task automatic test_disabled();
      do_reset();
      enable_i = 1'b0; req_valid_i = 4'hF;
      repeat (10) begin
         rand_addr();
         run_cycle();
         for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (a_rr[k] !== 4'b0 || a_en[k] !== 1'b0 || a_busy[k] !== 1'b0) begin
               n_err++;
               $display("FAIL disabled L=%0d: got rdy=%b en=%b busy=%b want 0000/0/0",
                        k+1, a_rr[k], a_en[k], a_busy[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst_i       = ($urandom_range(0, 79) == 0);
         enable_i    = ($urandom_range(0, 9) < 7);
         req_valid_i = N'($urandom());
         rand_addr();
         run_cycle();
         for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (act_pk[k] !== exp_pk[k]) begin
               n_err++;
               $display("FAIL random_model c=%0d L=%0d: got %h want %h", c, k+1, act_pk[k], exp_pk[k]);
            end
         end
      end
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; enable_i = 1'b0; req_valid_i = '0; req_addr_i = '0; bram_dout_i = '0;
      model_reset();
      @(posedge clk_i);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_ptr_skip();
      test_drain();
      test_reset_midflight();
      test_disabled();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
